// File: rtl/duck_hit_detector.sv
// Purpose: tests each new left click against the duck bounding box; emits a one-cycle hit strobe, keeps shots and a score.
// Latency: click edge sampled at edge N, clicked_duck high in the cycle after edge N+2; shots/score update on the same edge.
// Backpressure: none; clicks arriving outside ARMED (capture, check, cooldown, no shots left, not in GAME) are dropped.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   state[1:0]           game state (01 = GAME; anything else is treated as not-in-game)
//   mouse_left           button level, already synchronous to clk
//   mouse_xpos/ypos[11:0] cursor position in pixels
//   duck_xpos/ypos[9:0]  duck top-left corner
//   clicked_duck         registered one-cycle hit pulse
//   shots_left[1:0]      registered remaining shots for the current duck
//   hit_count[7:0]       registered hit score, saturating at 255
//   out_of_shots         registered level: in GAME with no shots left
module duck_hit_detector #(
    parameter int DUCK_W       = 64,
    parameter int DUCK_H       = 64,
    parameter int SHOTS        = 3,
    parameter int COOLDOWN_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic [9:0]  duck_xpos,
    input  logic [9:0]  duck_ypos,
    output logic        clicked_duck,
    output logic [1:0]  shots_left,
    output logic [7:0]  hit_count,
    output logic        out_of_shots
);

    localparam logic [1:0]    ST_GAME   = 2'b01;
    localparam int            CW        = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic [CW-1:0] CD_LOAD   = CW'(COOLDOWN_CYC - 1);
    localparam logic [CW-1:0] CD_ONE    = CW'(1);
    localparam logic [1:0]    SHOTS_L   = 2'(SHOTS);
    localparam logic [12:0]   DUCK_W_13 = 13'(DUCK_W);
    localparam logic [12:0]   DUCK_H_13 = 13'(DUCK_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_CHECK,
        S_COOLDOWN
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic          btn_q, btn_d;
    logic [11:0]   mx_q, mx_d, my_q, my_d;
    logic [9:0]    dx_q, dx_d, dy_q, dy_d;
    logic          in_box_q, in_box_d;
    logic [CW-1:0] cd_cnt_q, cd_cnt_d;
    logic          clicked_duck_q, clicked_duck_d;
    logic [1:0]    shots_left_q, shots_left_d;
    logic [7:0]    hit_count_q, hit_count_d;
    logic          out_of_shots_q, out_of_shots_d;

    logic          in_game;
    logic          click;
    logic [12:0]   mx13, my13, dx13, dy13;
    logic          in_box_c;

    assign in_game = (state == ST_GAME);
    assign click   = mouse_left & ~btn_q;

    // 13-bit compare: a duck near the 10-bit limit plus its size must not wrap past zero.
    assign mx13 = {1'b0, mx_q};
    assign my13 = {1'b0, my_q};
    assign dx13 = {3'b000, dx_q};
    assign dy13 = {3'b000, dy_q};
    assign in_box_c = (mx13 >= dx13) && (mx13 < dx13 + DUCK_W_13) &&
                      (my13 >= dy13) && (my13 < dy13 + DUCK_H_13);

    always_comb begin
        fsm_d          = fsm_q;
        btn_d          = mouse_left;
        mx_d           = mx_q;
        my_d           = my_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        in_box_d       = in_box_q;
        cd_cnt_d       = cd_cnt_q;
        clicked_duck_d = 1'b0;
        shots_left_d   = shots_left_q;
        hit_count_d    = hit_count_q;
        out_of_shots_d = in_game && (shots_left_q == 2'd0);

        if (!in_game) begin
            // Leaving GAME aborts anything in flight; score and shots hold for the END screen.
            fsm_d = S_IDLE;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    fsm_d        = S_ARMED;
                    shots_left_d = SHOTS_L;
                    hit_count_d  = 8'd0;
                end
                S_ARMED: begin
                    if (click && (shots_left_q != 2'd0)) begin
                        fsm_d = S_CAPTURE;
                        // Duck position is frozen here so a same-cycle position update is ignored.
                        mx_d  = mouse_xpos;
                        my_d  = mouse_ypos;
                        dx_d  = duck_xpos;
                        dy_d  = duck_ypos;
                    end
                end
                S_CAPTURE: begin
                    in_box_d = in_box_c;
                    fsm_d    = S_CHECK;
                end
                S_CHECK: begin
                    if (in_box_q) begin
                        clicked_duck_d = 1'b1;
                        shots_left_d   = SHOTS_L;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_d = hit_count_q + 8'd1;
                        end
                    end else begin
                        shots_left_d = shots_left_q - 2'd1;
                    end
                    cd_cnt_d = CD_LOAD;
                    fsm_d    = S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (cd_cnt_q == '0) begin
                        fsm_d = S_ARMED;
                    end else begin
                        cd_cnt_d = cd_cnt_q - CD_ONE;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q          <= S_IDLE;
            btn_q          <= 1'b0;
            mx_q           <= '0;
            my_q           <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            in_box_q       <= 1'b0;
            cd_cnt_q       <= '0;
            clicked_duck_q <= 1'b0;
            shots_left_q   <= SHOTS_L;
            hit_count_q    <= 8'd0;
            out_of_shots_q <= 1'b0;
        end else begin
            fsm_q          <= fsm_d;
            btn_q          <= btn_d;
            mx_q           <= mx_d;
            my_q           <= my_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            in_box_q       <= in_box_d;
            cd_cnt_q       <= cd_cnt_d;
            clicked_duck_q <= clicked_duck_d;
            shots_left_q   <= shots_left_d;
            hit_count_q    <= hit_count_d;
            out_of_shots_q <= out_of_shots_d;
        end
    end

    assign clicked_duck = clicked_duck_q;
    assign shots_left   = shots_left_q;
    assign hit_count    = hit_count_q;
    assign out_of_shots = out_of_shots_q;

endmodule

// File: tb/tb_duck_hit_detector.sv
// Purpose: directed, table-driven check of duck_hit_detector hit test, shots, score and corner sequences.
// Latency: expects clicked_duck in the cycle after the second edge following the sampled click edge.
// Backpressure: n/a (bench drives levels and observes registered outputs).
module tb_duck_hit_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state;
    logic        mouse_left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [9:0]  duck_xpos;
    logic [9:0]  duck_ypos;
    logic        clicked_duck;
    logic [1:0]  shots_left;
    logic [7:0]  hit_count;
    logic        out_of_shots;

    int n_cmp  = 0;
    int n_fail = 0;

    duck_hit_detector dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .mouse_left   (mouse_left),
        .mouse_xpos   (mouse_xpos),
        .mouse_ypos   (mouse_ypos),
        .duck_xpos    (duck_xpos),
        .duck_ypos    (duck_ypos),
        .clicked_duck (clicked_duck),
        .shots_left   (shots_left),
        .hit_count    (hit_count),
        .out_of_shots (out_of_shots)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit restart;
        int dx, dy, mx, my;
        bit hit;
        int shots, hits;
        bit oos;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One click lasting a single sample, then enough idle cycles to clear cooldown.
    task automatic shoot(input int dx, input int dy, input int mx, input int my,
                         input bit exp_hit, input bit do_chk, input string nm);
        duck_xpos  = 10'(dx);
        duck_ypos  = 10'(dy);
        mouse_xpos = 12'(mx);
        mouse_ypos = 12'(my);
        mouse_left = 1'b1;
        tick();                              // edge N
        mouse_left = 1'b0;
        if (do_chk) chk({nm, " pulse@N"}, int'(clicked_duck), 0);
        tick();                              // edge N+1
        if (do_chk) chk({nm, " pulse@N+1"}, int'(clicked_duck), 0);
        tick();                              // edge N+2
        if (do_chk) chk({nm, " pulse@N+2"}, int'(clicked_duck), int'(exp_hit));
        tick();                              // edge N+3
        if (do_chk) chk({nm, " pulse@N+3"}, int'(clicked_duck), 0);
        repeat (16) tick();
    endtask

    task automatic restart_game();
        state = 2'b10;
        tick();
        tick();
        state = 2'b01;
        tick();
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{1'b0, 100, 200, 130, 230, 1'b1, 3, 1, 1'b0};
        vecs[1]  = '{1'b0, 100, 200,  99, 230, 1'b0, 2, 1, 1'b0};
        vecs[2]  = '{1'b0, 100, 200, 164, 230, 1'b0, 1, 1, 1'b0};
        vecs[3]  = '{1'b0, 100, 200, 130, 264, 1'b0, 0, 1, 1'b1};
        vecs[4]  = '{1'b0, 100, 200, 130, 230, 1'b0, 0, 1, 1'b1};
        vecs[5]  = '{1'b1, 896, 640, 896, 640, 1'b1, 3, 1, 1'b0};
        vecs[6]  = '{1'b0, 896, 640, 959, 703, 1'b1, 3, 2, 1'b0};
        vecs[7]  = '{1'b0,   0,   0,   0,   0, 1'b1, 3, 3, 1'b0};
        vecs[8]  = '{1'b0,   0,   0,  64,   0, 1'b0, 2, 3, 1'b0};
        vecs[9]  = '{1'b0,   0,   0,  63,  63, 1'b1, 3, 4, 1'b0};
        vecs[10] = '{1'b0, 896, 640, 960, 703, 1'b0, 2, 4, 1'b0};
        vecs[11] = '{1'b0,1023,1023,1086,1086, 1'b1, 3, 5, 1'b0};

        rst        = 1'b1;
        state      = 2'b00;
        mouse_left = 1'b0;
        mouse_xpos = '0;
        mouse_ypos = '0;
        duck_xpos  = '0;
        duck_ypos  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset clicked_duck", int'(clicked_duck), 0);
        chk("reset shots_left",   int'(shots_left),   3);
        chk("reset hit_count",    int'(hit_count),    0);
        chk("reset out_of_shots", int'(out_of_shots), 0);

        state = 2'b01;
        tick();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].restart) restart_game();
            shoot(vecs[i].dx, vecs[i].dy, vecs[i].mx, vecs[i].my, vecs[i].hit, 1'b1,
                  $sformatf("vec%0d", i));
            chk($sformatf("vec%0d shots_left", i),   int'(shots_left),   vecs[i].shots);
            chk($sformatf("vec%0d hit_count", i),    int'(hit_count),    vecs[i].hits);
            chk($sformatf("vec%0d out_of_shots", i), int'(out_of_shots), int'(vecs[i].oos));
        end

        // Button held for 100 cycles gives exactly one evaluation.
        duck_xpos  = 10'd100;
        duck_ypos  = 10'd200;
        mouse_xpos = 12'd130;
        mouse_ypos = 12'd230;
        mouse_left = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clicked_duck) pulses++;
        end
        mouse_left = 1'b0;
        tick();
        tick();
        chk("held pulses", pulses, 1);
        chk("held hit_count", int'(hit_count), 6);

        // Miss, then a second press during cooldown that must be ignored.
        mouse_xpos = 12'd99;
        mouse_left = 1'b1;
        tick();
        mouse_left = 1'b0;
        repeat (3) tick();
        mouse_left = 1'b1;
        tick();
        mouse_left = 1'b0;
        repeat (20) tick();
        chk("cooldown press shots_left", int'(shots_left), 2);
        shoot(100, 200, 99, 230, 1'b0, 1'b1, "after cooldown");
        chk("after cooldown shots_left", int'(shots_left), 1);

        // Leave GAME while the click is in CAPTURE: no pulse, values held.
        mouse_xpos = 12'd130;
        mouse_left = 1'b1;
        tick();
        state = 2'b10;
        tick();
        mouse_left = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (clicked_duck) pulses++;
            tick();
        end
        chk("abort pulses", pulses, 0);
        chk("abort hit_count held", int'(hit_count), 6);
        chk("abort shots_left held", int'(shots_left), 1);
        chk("abort out_of_shots", int'(out_of_shots), 0);
        state = 2'b01;
        tick();
        chk("reentry hit_count", int'(hit_count), 0);
        chk("reentry shots_left", int'(shots_left), 3);

        // Saturate the score.
        for (int i = 0; i < 255; i++) shoot(100, 200, 130, 230, 1'b1, 1'b0, "sat");
        chk("sat hit_count 255", int'(hit_count), 255);
        shoot(100, 200, 130, 230, 1'b1, 1'b1, "sat+1");
        chk("sat+1 hit_count", int'(hit_count), 255);
        chk("sat+1 shots_left", int'(shots_left), 3);

        // Burn a shot so reset visibly restores shots_left, then reset during CHECK.
        shoot(100, 200, 99, 230, 1'b0, 1'b0, "burn");
        mouse_xpos = 12'd130;
        mouse_left = 1'b1;
        tick();
        mouse_left = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst-in-check clicked_duck", int'(clicked_duck), 0);
        chk("rst-in-check shots_left",   int'(shots_left),   3);
        chk("rst-in-check hit_count",    int'(hit_count),    0);
        chk("rst-in-check out_of_shots", int'(out_of_shots), 0);
        rst = 1'b0;
        tick();
        chk("post-rst clicked_duck", int'(clicked_duck), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
